// File: rtl/javk_bus_arbiter.sv
// Round-robin two-master arbiter for the JAVK memory bus with burst cap and turnaround gap.
// Accept-to-ack latency 2 cycles; a master is stalled by holding req until gnt&req meet at an edge.
module javk_bus_arbiter #(
  parameter int MAX_BURST   = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [15:0] m0_addr,
  input  logic        m0_rw,
  input  logic [7:0]  m0_wdata,
  output logic        m0_gnt,
  output logic        m0_ack,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic [15:0] m1_addr,
  input  logic        m1_rw,
  input  logic [7:0]  m1_wdata,
  output logic        m1_gnt,
  output logic        m1_ack,
  output logic [7:0]  m1_rdata,
  output logic [15:0] addrbus,
  output logic        rw,
  output logic [7:0]  dout,
  output logic        doe,
  input  logic [7:0]  din
);

  localparam logic [7:0] MAXB      = 8'(MAX_BURST);
  localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, TURN} state_t;

  state_t      state;
  logic [7:0]  burst;
  logic [1:0]  turn_cnt;
  logic        rr;
  logic        turn_to;
  logic        pend_vld;
  logic        pend_m;
  logic        pend_rw;

  logic        acc0, acc1, acc;
  logic        own_req, oth_req;
  logic [15:0] sel_addr;
  logic        sel_rw;
  logic [7:0]  sel_wdata;
  logic [7:0]  burst_inc;

  assign acc0      = m0_gnt & m0_req;
  assign acc1      = m1_gnt & m1_req;
  assign acc       = acc0 | acc1;
  assign own_req   = (state == GNT1) ? m1_req : m0_req;
  assign oth_req   = (state == GNT1) ? m0_req : m1_req;
  assign sel_addr  = acc1 ? m1_addr  : m0_addr;
  assign sel_rw    = acc1 ? m1_rw    : m0_rw;
  assign sel_wdata = acc1 ? m1_wdata : m0_wdata;
  // Saturates so an uncontested owner can stream indefinitely.
  assign burst_inc = (burst == MAXB) ? burst : burst + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      m0_gnt   <= 1'b0;
      m1_gnt   <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= 8'h00;
      m1_rdata <= 8'h00;
      addrbus  <= 16'h0000;
      rw       <= 1'b1;
      dout     <= 8'h00;
      doe      <= 1'b0;
      burst    <= 8'h00;
      turn_cnt <= 2'd0;
      rr       <= 1'b1;
      turn_to  <= 1'b0;
      pend_vld <= 1'b0;
      pend_m   <= 1'b0;
      pend_rw  <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;

      if (acc) begin
        addrbus <= sel_addr;
        rw      <= sel_rw;
        dout    <= sel_wdata;
        doe     <= ~sel_rw;
        rr      <= acc1;
        burst   <= burst_inc;
      end else begin
        rw  <= 1'b1;
        doe <= 1'b0;
      end

      // Completion stage: din is valid during the bus cycle of the previous accept.
      pend_vld <= acc;
      pend_m   <= acc1;
      pend_rw  <= sel_rw;
      if (pend_vld) begin
        if (pend_m) begin
          m1_ack <= 1'b1;
          if (pend_rw) m1_rdata <= din;
        end else begin
          m0_ack <= 1'b1;
          if (pend_rw) m0_rdata <= din;
        end
      end

      case (state)
        IDLE: begin
          if (m0_req && (!m1_req || rr)) begin
            state  <= GNT0;
            m0_gnt <= 1'b1;
            burst  <= 8'h00;
          end else if (m1_req) begin
            state  <= GNT1;
            m1_gnt <= 1'b1;
            burst  <= 8'h00;
          end
        end
        GNT0, GNT1: begin
          if (!own_req || (oth_req && burst_inc == MAXB)) begin
            m0_gnt <= 1'b0;
            m1_gnt <= 1'b0;
            if (oth_req) begin
              state    <= TURN;
              turn_cnt <= 2'd0;
              turn_to  <= (state == GNT0);
            end else begin
              state <= IDLE;
            end
          end
        end
        TURN: begin
          if (turn_cnt == TURN_LAST) begin
            state    <= turn_to ? GNT1 : GNT0;
            m0_gnt   <= ~turn_to;
            m1_gnt   <= turn_to;
            burst    <= 8'h00;
            turn_cnt <= 2'd0;
          end else begin
            turn_cnt <= turn_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_javk_bus_arbiter.sv
// Directed bench for javk_bus_arbiter: instance 0 uses MAX_BURST=4/TURN_CYCLES=1,
// instance 1 uses MAX_BURST=4/TURN_CYCLES=3; both share the same master stimulus.
module tb_javk_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [15:0] m0_addr, m1_addr;
  logic        m0_rw, m1_rw;
  logic [7:0]  m0_wdata, m1_wdata;
  logic [7:0]  din;

  logic        m0_gnt [2];
  logic        m1_gnt [2];
  logic        m0_ack [2];
  logic        m1_ack [2];
  logic [7:0]  m0_rdata [2];
  logic [7:0]  m1_rdata [2];
  logic [15:0] addrbus [2];
  logic        rw [2];
  logic [7:0]  dout [2];
  logic        doe [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  javk_bus_arbiter #(.MAX_BURST(4), .TURN_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_rw(m0_rw), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt[0]), .m0_ack(m0_ack[0]), .m0_rdata(m0_rdata[0]),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_rw(m1_rw), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt[0]), .m1_ack(m1_ack[0]), .m1_rdata(m1_rdata[0]),
    .addrbus(addrbus[0]), .rw(rw[0]), .dout(dout[0]), .doe(doe[0]), .din(din)
  );

  javk_bus_arbiter #(.MAX_BURST(4), .TURN_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_rw(m0_rw), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt[1]), .m0_ack(m0_ack[1]), .m0_rdata(m0_rdata[1]),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_rw(m1_rw), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt[1]), .m1_ack(m1_ack[1]), .m1_rdata(m1_rdata[1]),
    .addrbus(addrbus[1]), .rw(rw[1]), .dout(dout[1]), .doe(doe[1]), .din(din)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns into cycle 0, the first cycle after the reset edge.
  task automatic do_reset();
    rst    = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int gcnt, acnt, m1acnt, first1, last0, both;

    m0_addr = 16'h0; m0_rw = 1'b1; m0_wdata = 8'h0;
    m1_addr = 16'h0; m1_rw = 1'b1; m1_wdata = 8'h0;
    din = 8'hA5;

    // Reset state, then a single M0 read of 0x1234.
    do_reset();
    check("rst_m0_gnt", m0_gnt[0], 0);
    check("rst_m1_gnt", m1_gnt[0], 0);
    check("rst_m0_ack", m0_ack[0], 0);
    check("rst_m0_rdata", m0_rdata[0], 0);
    check("rst_addrbus", addrbus[0], 0);
    check("rst_rw", rw[0], 1);
    check("rst_doe", doe[0], 0);
    check("rst_dout", dout[0], 0);
    check("rst_b_gnt", m0_gnt[1] | m1_gnt[1], 0);
    m0_req = 1'b1; m0_addr = 16'h1234; m0_rw = 1'b1;
    nxt();
    check("rd_gnt_c1", m0_gnt[0], 1);
    nxt();
    m0_req = 1'b0;
    check("rd_addr_c2", addrbus[0], 16'h1234);
    check("rd_rw_c2", rw[0], 1);
    check("rd_doe_c2", doe[0], 0);
    check("rd_noack_c2", m0_ack[0], 0);
    nxt();
    check("rd_ack_c3", m0_ack[0], 1);
    check("rd_rdata_c3", m0_rdata[0], 8'hA5);
    check("rd_gnt_c3", m0_gnt[0], 0);
    nxt();
    check("rd_ack_c4", m0_ack[0], 0);

    // Single M1 write of 0x55 to 0x8000; rdata must stay at its reset value.
    do_reset();
    m1_req = 1'b1; m1_addr = 16'h8000; m1_rw = 1'b0; m1_wdata = 8'h55;
    nxt();
    check("wr_gnt_c1", m1_gnt[0], 1);
    nxt();
    m1_req = 1'b0;
    check("wr_addr_c2", addrbus[0], 16'h8000);
    check("wr_rw_c2", rw[0], 0);
    check("wr_doe_c2", doe[0], 1);
    check("wr_dout_c2", dout[0], 8'h55);
    nxt();
    check("wr_doe_c3", doe[0], 0);
    check("wr_rw_c3", rw[0], 1);
    check("wr_ack_c3", m1_ack[0], 1);
    check("wr_rdata_c3", m1_rdata[0], 8'h00);
    nxt();
    check("wr_ack_c4", m1_ack[0], 0);

    // Both request from reset: M0 first, 2 transfers, turnaround, M1, then round-robin.
    do_reset();
    m0_req = 1'b1; m0_addr = 16'h0100; m0_rw = 1'b1;
    m1_req = 1'b1; m1_addr = 16'h0200; m1_rw = 1'b0; m1_wdata = 8'h3C;
    nxt();
    check("rr_m0_gnt_c1", m0_gnt[0], 1);
    check("rr_m1_gnt_c1", m1_gnt[0], 0);
    nxt();
    nxt();
    m0_req = 1'b0;
    check("rr_addr_c3", addrbus[0], 16'h0100);
    check("rr_doe_c3", doe[0], 0);
    nxt();
    check("rr_turn_gnt_c4", m0_gnt[0] | m1_gnt[0], 0);
    check("rr_turn_doe_c4", doe[0], 0);
    check("rr_turn_rw_c4", rw[0], 1);
    check("rr_turn_ack_c4", m0_ack[0], 1);
    nxt();
    check("rr_m1_gnt_c5", m1_gnt[0], 1);
    check("rr_m0_gnt_c5", m0_gnt[0], 0);
    nxt();
    m1_req = 1'b0;
    check("rr_m1_addr_c6", addrbus[0], 16'h0200);
    check("rr_m1_doe_c6", doe[0], 1);
    check("rr_m1_dout_c6", dout[0], 8'h3C);
    nxt();
    check("rr_m1_ack_c7", m1_ack[0], 1);
    m0_req = 1'b1; m1_req = 1'b1;
    nxt();
    check("rr_tie_after_m1", m0_gnt[0], 1);
    check("rr_tie_after_m1_n", m1_gnt[0], 0);
    nxt();
    m0_req = 1'b0; m1_req = 1'b0;
    nxt();
    m0_req = 1'b1; m1_req = 1'b1;
    nxt();
    check("rr_tie_after_m0", m1_gnt[0], 1);
    check("rr_tie_after_m0_n", m0_gnt[0], 0);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) nxt();

    // Burst cap of 4 with M1 joining at cycle 2.
    do_reset();
    m0_req = 1'b1; m0_addr = 16'h1000; m0_rw = 1'b1;
    m1_addr = 16'h2000; m1_rw = 1'b0; m1_wdata = 8'h11;
    gcnt = 0; acnt = 0; m1acnt = 0; first1 = 0; both = 0;
    for (int c = 1; c <= 10; c++) begin
      nxt();
      if (m0_gnt[0] && c <= 8) gcnt++;
      if (m0_ack[0]) acnt++;
      if (m1_ack[0]) m1acnt++;
      if (m1_gnt[0] && first1 == 0) first1 = c;
      if (m0_gnt[0] && m1_gnt[0]) both++;
      if (c == 2) m1_req = 1'b1;
      if (c == 7) m1_req = 1'b0;
      if (c == 9) m0_req = 1'b0;
    end
    check("burst_m0_gnt_cycles", gcnt, 4);
    check("burst_m0_acks", acnt, 4);
    check("burst_m1_first_gnt", first1, 6);
    check("burst_m1_acks", m1acnt, 1);
    check("burst_dual_gnt", both, 0);
    repeat (2) nxt();

    // Uncontested M0 streams 20 transfers without a break.
    do_reset();
    m0_req = 1'b1; m0_addr = 16'h0F00; m0_rw = 1'b1;
    gcnt = 0; acnt = 0; first1 = 0;
    for (int c = 1; c <= 24; c++) begin
      nxt();
      if (m0_gnt[0] && c <= 20) gcnt++;
      if (m0_ack[0]) acnt++;
      if (m1_gnt[0]) first1++;
      if (c == 21) m0_req = 1'b0;
    end
    check("stream_gnt_cycles", gcnt, 20);
    check("stream_acks", acnt, 20);
    check("stream_m1_gnt", first1, 0);

    // Three-cycle turnaround on the second instance, both masters writing.
    do_reset();
    m0_req = 1'b1; m0_addr = 16'h4000; m0_rw = 1'b0; m0_wdata = 8'h99;
    m1_req = 1'b1; m1_addr = 16'h3000; m1_rw = 1'b0; m1_wdata = 8'h77;
    last0 = 0; first1 = 0; both = 0;
    for (int c = 1; c <= 12; c++) begin
      nxt();
      if (doe[1] && addrbus[1] == 16'h4000) last0 = c;
      if (doe[1] && addrbus[1] == 16'h3000 && first1 == 0) first1 = c;
      if (m0_gnt[1] && m1_gnt[1]) both++;
      if (c == 10) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
    check("turn3_last_m0_bus", last0, 5);
    check("turn3_first_m1_bus", first1, 9);
    check("turn3_idle_gap", first1 - last0 - 1, 3);
    check("turn3_dual_gnt", both, 0);
    repeat (2) nxt();

    // Reset asserted after 2 accepted M0 reads; pending ack must vanish.
    do_reset();
    din = 8'h5A;
    m0_req = 1'b1; m0_addr = 16'h1234; m0_rw = 1'b1;
    nxt();
    check("mid_gnt_c1", m0_gnt[0], 1);
    nxt();
    nxt();
    check("mid_ack_c3", m0_ack[0], 1);
    check("mid_rdata_c3", m0_rdata[0], 8'h5A);
    rst = 1'b0;
    nxt();
    check("mid_rst_gnt", m0_gnt[0], 0);
    check("mid_rst_ack", m0_ack[0], 0);
    check("mid_rst_rdata", m0_rdata[0], 8'h00);
    check("mid_rst_addr", addrbus[0], 16'h0000);
    check("mid_rst_rw", rw[0], 1);
    check("mid_rst_doe", doe[0], 0);
    check("mid_rst_dout", dout[0], 8'h00);
    rst = 1'b1;
    m1_req = 1'b1; m1_addr = 16'h2222; m1_rw = 1'b1;
    nxt();
    check("mid_regrant_m0", m0_gnt[0], 1);
    check("mid_regrant_m1", m1_gnt[0], 0);
    check("mid_no_stale_ack", m0_ack[0], 0);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (4) nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/javk_bus_arbiter.md
Name: javk_bus_arbiter

Overview:
- Shares the JAVK external memory bus (16-bit address, 8-bit data, rw) between two masters: master 0 (JAVK core) and master 1 (DMA/debug port).
- Round-robin arbitration, bounded burst length and a turnaround gap on ownership change.
- Drives the registered bus outputs; the top level turns dout/doe into the tristate databus.

Parameters:
- MAX_BURST, 8, transfers an owner may make while the other master waits (1..255).
- TURN_CYCLES, 1, idle bus cycles inserted between owners (1..3).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-low reset
- m0_req, m1_req  in  1  master wants a transfer; hold with addr/rw/wdata stable until accepted
- m0_addr, m1_addr  in  16  transfer address
- m0_rw, m1_rw  in  1  1 = read, 0 = write
- m0_wdata, m1_wdata  in  8  write data
- m0_gnt, m1_gnt  out  1  master owns bus (registered)
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  8  read data, valid while ack high
- addrbus  out  16  bus address (registered)
- rw  out  1  bus direction, 1 = read
- dout  out  8  bus write data
- doe  out  1  bus data output enable
- din  in  8  bus read data

Behaviour:
- Reset (rst low at edge): state IDLE; gnt=0, ack=0, rdata=0, addrbus=0, rw=1, dout=0, doe=0, burst count=0, turn count=0, rr pointer=1 (master 0 wins the first tie). Any in-flight transfer is discarded and no ack is issued.
- States:
  - IDLE: if one req is high, go to GNTx. If both, go to the master not equal to the rr pointer. Otherwise stay.
  - GNTx: the grant is held. See the transitions below.
  - TURN: both gnt low, bus idle for TURN_CYCLES cycles, then go to GNTy where y is the other master.
- Accept: at an edge where mx_gnt=1 and mx_req=1, the transfer is accepted.
  - Next cycle: addrbus=mx_addr, rw=mx_rw, dout=mx_wdata, doe=~mx_rw.
  - The edge after that captures din into mx_rdata (reads only) and pulses mx_ack for one cycle (reads and writes).
  - Latency is 2 cycles from accept to ack.
  - Back-to-back accepts give one bus cycle per clock.
- Non-accept cycle: next cycle rw=1, doe=0, addrbus and dout hold their previous values.
- Accept updates burst count (+1) and sets rr pointer=x.
- GNTx transitions at each edge:
  - If owner req is low and other req is high, go to TURN.
  - If owner req is low and other req is low, go to IDLE.
  - If burst count (including this accept) = MAX_BURST and other req is high, go to TURN. This last transfer is still accepted.
  - Otherwise stay. The burst count saturates at MAX_BURST while the other master is idle.
- Burst count is cleared on entry to GNTx.
- gnt deasserts in the cycle after the deciding edge. A master must not assume acceptance unless gnt and req were both high at the edge.
- Owner change always passes through TURN (doe=0 for at least TURN_CYCLES). Entry from IDLE needs no TURN.
- A req dropped while gnt=0 is not an error; nothing is recorded.
- At most one ack is high per cycle. An ack for the previous owner may occur during TURN.

Test Plan:
- M0 read addr 0x1234 only, din=0xA5: m0_gnt at cycle 1. Accept at edge 1. addrbus=0x1234, rw=1, doe=0 in cycle 2. m0_ack=1, m0_rdata=0xA5 in cycle 3. Then IDLE.
- M1 write 0x55 to 0x8000 only: addrbus=0x8000, rw=0, doe=1, dout=0x55 for exactly one cycle. m1_ack pulses. m1_rdata unchanged.
- Both req from reset: M0 granted first. M0 drops req after 2 transfers. Bus shows 1 cycle of doe=0/rw=1, then m1_gnt=1. Next simultaneous request from IDLE goes to M1's opposite (M0) only if M1 was last served.
- MAX_BURST=4, M0 continuous, M1 requests at cycle 2: exactly 4 M0 transfers, then TURN, then M1 granted. With M1 idle, M0 runs 20 consecutive transfers uninterrupted.
- TURN_CYCLES=3 handover: exactly 3 idle bus cycles between last M0 bus cycle and first M1 bus cycle; no cycle with both gnt high.
- Reset low mid-burst (M0, after 2 of 4 accepts): next cycle all outputs at reset values, no ack for pending transfer. After release, M0 is granted first again.
